crg_job_sched: RTL and testbench
================================

Name: crg_job_sched

Overview:
- Job scheduler and sequencer for the CRG core.
- Accepts job descriptors (key, width, mode, counter range, party) through a valid/ready queue.
- Runs one job at a time: drives the CRG configuration, pulses run, counts dvld beats until the range completes, then retires the job.
- Sits between the host-side loader and the CRG instance, in the CRG clock domain; adds timeout, abort and error reporting.

Parameters:
- DEPTH, 4, job FIFO depth; power of two, ≥2
- W_KEY, 128, key width
- W_WIDTH, 8, width field
- W_MODE, 4, mode field
- W_CNT, 16, counter field
- RUN_CYC, 7, cycles crg_run_o is held high per job
- TIMEOUT, 1024, max idle cycles between dvld beats before error

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- job_vld_i  in  1  descriptor valid
- job_rdy_o  out  1  queue can accept
- job_key_i  in  W_KEY  key
- job_width_i  in  W_WIDTH  width
- job_mode_i  in  W_MODE  mode
- job_cnt_start_i  in  W_CNT  first counter
- job_cnt_end_i  in  W_CNT  last counter (inclusive)
- job_party_i  in  1  party bit
- abort_i  in  1  abandon current job, flush queue
- clr_err_i  in  1  clear sticky errors
- crg_key_o / crg_width_o / crg_mode_o / crg_cnt_start_o / crg_cnt_end_o / crg_party_o  out  matching widths  CRG config
- crg_run_o  out  1  run strobe to CRG
- crg_dvld_i  in  1  CRG output beat valid
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse on job retirement
- jobs_done_o  out  16  retired-job counter, wraps
- err_timeout_o  out  1  sticky timeout error
- err_range_o  out  1  sticky bad-range error

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0, job_rdy_o = 1.
  - FIFO empty, state IDLE, counters 0.
  - Reset mid-job drops the job and all queued jobs.
- Queue:
  - Push when job_vld_i && job_rdy_o.
  - job_rdy_o = !full, computed from occupancy only.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- FSM states: IDLE, LOAD, RUN, WAIT, DONE.
  - IDLE: if FIFO non-empty → LOAD (pop at this edge).
  - LOAD:
    - Register the popped descriptor into the crg_*_o config outputs.
    - exp = cnt_end − cnt_start + 1, computed on W_CNT+1 bits.
    - If cnt_end < cnt_start: set err_range_o, do not pulse run, → IDLE.
    - Otherwise → RUN.
  - RUN: crg_run_o = 1 for exactly RUN_CYC cycles, then → WAIT.
  - WAIT:
    - Count crg_dvld_i beats; beats arriving during RUN also count.
    - When the beat count equals exp → DONE.
    - Idle counter resets on each beat; if it reaches TIMEOUT → set err_timeout_o, → IDLE, job dropped.
  - DONE: done_o = 1 for one cycle; jobs_done_o increments (wraps 0xFFFF → 0); → IDLE.
- Config outputs hold stable from LOAD through DONE and keep their last value in IDLE.
- dvld in IDLE is ignored; no counter changes.
- abort_i (any state ≠ IDLE, or with a non-empty FIFO):
  - Next state IDLE, crg_run_o drops at that edge, FIFO flushed.
  - Sets no error flag and does not pulse done_o.
  - A push coincident with abort is discarded.
- clr_err_i clears both error flags. A set event in the same cycle as clr_err_i wins.
- Latency, job pushed at edge t into an empty idle block:
  - Pop at t+1, config valid at t+2.
  - crg_run_o high t+2 … t+2+RUN_CYC−1.

Test Plan:
- Single job, cnt 5..7 (exp=3): push, then 3 dvld beats spaced 7 cycles → run high 7 cycles starting 2 cycles after push; done_o pulse 1 cycle after 3rd beat; jobs_done_o=1; busy_o low afterwards.
- Back-to-back: 5 jobs pushed continuously with DEPTH=4 → job_rdy_o low after 4 stored while first runs; all 5 retire in order; config outputs match each descriptor in turn; jobs_done_o=5.
- Bad range, cnt_start=10, cnt_end=9 → err_range_o=1; no run pulse; next queued job still executes; clr_err_i clears the flag.
- Timeout: job exp=4, only 2 beats then silence → err_timeout_o set exactly TIMEOUT cycles after the 2nd beat; no done_o; state IDLE.
- Abort during WAIT with 2 jobs queued → busy_o low next cycle; FIFO empty, job_rdy_o=1; no errors; jobs_done_o unchanged.
- Async reset asserted mid-RUN → crg_run_o and all outputs 0 immediately, without a clock edge; after release, a new job runs normally.

Source files
------------

// File: rtl/crg_job_sched.sv
// Job scheduler for the CRG core: queues descriptors, runs them one at a time,
// counts output beats and retires, times out or aborts each job.
`timescale 1ns/1ps
module crg_job_sched #(
  parameter int DEPTH   = 4,
  parameter int W_KEY   = 128,
  parameter int W_WIDTH = 8,
  parameter int W_MODE  = 4,
  parameter int W_CNT   = 16,
  parameter int RUN_CYC = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               job_vld_i,
  output logic               job_rdy_o,
  input  logic [W_KEY-1:0]   job_key_i,
  input  logic [W_WIDTH-1:0] job_width_i,
  input  logic [W_MODE-1:0]  job_mode_i,
  input  logic [W_CNT-1:0]   job_cnt_start_i,
  input  logic [W_CNT-1:0]   job_cnt_end_i,
  input  logic               job_party_i,
  input  logic               abort_i,
  input  logic               clr_err_i,
  output logic [W_KEY-1:0]   crg_key_o,
  output logic [W_WIDTH-1:0] crg_width_o,
  output logic [W_MODE-1:0]  crg_mode_o,
  output logic [W_CNT-1:0]   crg_cnt_start_o,
  output logic [W_CNT-1:0]   crg_cnt_end_o,
  output logic               crg_party_o,
  output logic               crg_run_o,
  input  logic               crg_dvld_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        jobs_done_o,
  output logic               err_timeout_o,
  output logic               err_range_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = W_KEY + W_WIDTH + W_MODE + 2 * W_CNT + 1;
  localparam int RW = $clog2(RUN_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, DONE} state_t;

  state_t              state, nxt;
  logic [DW-1:0]       mem [DEPTH];
  logic [DW-1:0]       head;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                push, pop, full, empty;
  logic [W_KEY-1:0]    h_key;
  logic [W_WIDTH-1:0]  h_width;
  logic [W_MODE-1:0]   h_mode;
  logic [W_CNT-1:0]    h_start, h_end;
  logic                h_party, bad_range;
  logic [W_CNT:0]      target, target_calc, beats, beats_nxt;
  logic [RW-1:0]       run_cnt;
  logic [TW-1:0]       idle_cnt;
  logic                idle_hit, range_set, tmo_set;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign job_rdy_o = !full;
  assign push      = job_vld_i && !full && !abort_i;
  assign pop       = (state == IDLE) && !empty && !abort_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Descriptor storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {job_key_i, job_width_i, job_mode_i,
                              job_cnt_start_i, job_cnt_end_i, job_party_i};
    if (pop)  head <= mem[rd_ptr];
  end

  assign {h_key, h_width, h_mode, h_start, h_end, h_party} = head;
  assign bad_range   = (h_end < h_start);
  assign target_calc = {1'b0, h_end} - {1'b0, h_start} + (W_CNT+1)'(1);
  assign beats_nxt   = beats + (W_CNT+1)'(crg_dvld_i);
  assign idle_hit    = !crg_dvld_i && (idle_cnt >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!empty) nxt = LOAD;
      LOAD:    nxt = bad_range ? IDLE : RUN;
      RUN:     if (run_cnt == RW'(RUN_CYC - 1)) nxt = WAIT;
      WAIT: begin
        if (beats_nxt == target) nxt = DONE;
        else if (idle_hit)       nxt = IDLE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_i) nxt = IDLE;
  end

  // Beats seen during RUN count toward the target, so counting starts there.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_cnt  <= '0;
      beats    <= '0;
      idle_cnt <= '0;
      target   <= '0;
    end else if (state == LOAD) begin
      run_cnt  <= '0;
      beats    <= '0;
      idle_cnt <= '0;
      target   <= target_calc;
    end else if (state == RUN || state == WAIT) begin
      if (state == RUN) run_cnt <= run_cnt + RW'(1);
      beats <= beats_nxt;
      if (crg_dvld_i)                     idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign range_set = (state == LOAD) && bad_range && !abort_i;
  assign tmo_set   = (state == WAIT) && !abort_i && (beats_nxt != target) && idle_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_range_o   <= 1'b0;
      err_timeout_o <= 1'b0;
      jobs_done_o   <= '0;
    end else begin
      if (range_set)      err_range_o <= 1'b1;
      else if (clr_err_i) err_range_o <= 1'b0;
      if (tmo_set)        err_timeout_o <= 1'b1;
      else if (clr_err_i) err_timeout_o <= 1'b0;
      if (state == WAIT && nxt == DONE) jobs_done_o <= jobs_done_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crg_key_o       <= '0;
      crg_width_o     <= '0;
      crg_mode_o      <= '0;
      crg_cnt_start_o <= '0;
      crg_cnt_end_o   <= '0;
      crg_party_o     <= 1'b0;
    end else if (state == LOAD && !abort_i) begin
      crg_key_o       <= h_key;
      crg_width_o     <= h_width;
      crg_mode_o      <= h_mode;
      crg_cnt_start_o <= h_start;
      crg_cnt_end_o   <= h_end;
      crg_party_o     <= h_party;
    end
  end

  assign crg_run_o = (state == RUN);
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_crg_job_sched.sv
// Scoreboard bench for crg_job_sched: a CRG stand-in emits beats, a monitor
// pops expected retire/error events as the DUT reports them.
`timescale 1ns/1ps
module tb_crg_job_sched;
  localparam int DEPTH = 4, W_KEY = 128, W_WIDTH = 8, W_MODE = 4, W_CNT = 16;
  localparam int RUN_CYC = 7, TIMEOUT = 1024;
  localparam logic [1:0] K_DONE = 2'd0, K_RANGE = 2'd1, K_TMO = 2'd2;

  typedef struct packed {
    logic [127:0] key;
    logic [7:0]   width;
    logic [3:0]   mode;
    logic [15:0]  cs;
    logic [15:0]  ce;
    logic         party;
  } job_t;
  typedef struct packed {
    logic [1:0]  kind;
    job_t        job;
    logic [15:0] jd;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic job_vld = 1'b0, job_party = 1'b0, abort = 1'b0, clr_err = 1'b0, crg_dvld = 1'b0;
  logic [127:0] job_key = '0;
  logic [7:0] job_width = '0;
  logic [3:0] job_mode = '0;
  logic [15:0] job_cnt_start = '0, job_cnt_end = '0;
  logic job_rdy, crg_party, crg_run, busy, done, err_timeout, err_range;
  logic [127:0] crg_key;
  logic [7:0] crg_width;
  logic [3:0] crg_mode;
  logic [15:0] crg_cnt_start, crg_cnt_end, jobs_done;

  exp_t sb[$];
  int n_chk = 0, n_err = 0, cyc = 0, last_beat_cyc = 0, run_pulses = 0;
  int beat_gap = 7, beat_limit = 1000, exp_jobs = 0;

  crg_job_sched #(.DEPTH(DEPTH), .W_KEY(W_KEY), .W_WIDTH(W_WIDTH), .W_MODE(W_MODE),
                  .W_CNT(W_CNT), .RUN_CYC(RUN_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .job_vld_i(job_vld), .job_rdy_o(job_rdy),
    .job_key_i(job_key), .job_width_i(job_width), .job_mode_i(job_mode),
    .job_cnt_start_i(job_cnt_start), .job_cnt_end_i(job_cnt_end), .job_party_i(job_party),
    .abort_i(abort), .clr_err_i(clr_err),
    .crg_key_o(crg_key), .crg_width_o(crg_width), .crg_mode_o(crg_mode),
    .crg_cnt_start_o(crg_cnt_start), .crg_cnt_end_o(crg_cnt_end), .crg_party_o(crg_party),
    .crg_run_o(crg_run), .crg_dvld_i(crg_dvld), .busy_o(busy), .done_o(done),
    .jobs_done_o(jobs_done), .err_timeout_o(err_timeout), .err_range_o(err_range)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic chk_cfg(input string tag, input job_t j);
    chk({tag, "_key"}, crg_key, j.key);
    chk({tag, "_width"}, crg_width, j.width);
    chk({tag, "_mode"}, crg_mode, j.mode);
    chk({tag, "_start"}, crg_cnt_start, j.cs);
    chk({tag, "_end"}, crg_cnt_end, j.ce);
    chk({tag, "_party"}, crg_party, j.party);
  endtask

  function automatic job_t mk(input logic [127:0] k, input logic [7:0] w, input logic [3:0] m,
                              input logic [15:0] s, input logic [15:0] e, input logic p);
    job_t j;
    j.key = k; j.width = w; j.mode = m; j.cs = s; j.ce = e; j.party = p;
    return j;
  endfunction

  task automatic expect_ev(input logic [1:0] kind, input job_t j);
    exp_t e;
    if (kind == K_DONE) exp_jobs++;
    e.kind = kind; e.job = j; e.jd = 16'(exp_jobs);
    sb.push_back(e);
  endtask

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic push_job(input job_t j);
    int n = 0;
    job_key = j.key; job_width = j.width; job_mode = j.mode;
    job_cnt_start = j.cs; job_cnt_end = j.ce; job_party = j.party; job_vld = 1'b1;
    while (!job_rdy && n < 500) begin @(negedge clk); n++; end
    chk("push_rdy", job_rdy, 1'b1);
    @(negedge clk);
    job_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0, quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk({tag, "_idle_reached"}, quiet >= 3, 1'b1);
  endtask

  // CRG stand-in: after run rises, emit min(range, beat_limit) beats every beat_gap cycles.
  initial begin : crg_model
    int left, gap, n;
    logic prev_run;
    left = 0; gap = 0; n = 0; prev_run = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        crg_dvld = 1'b0; left = 0; prev_run = 1'b0;
      end else begin
        if (crg_run && !prev_run) begin
          n = (crg_cnt_end < crg_cnt_start) ? 0 : int'(crg_cnt_end) - int'(crg_cnt_start) + 1;
          left = (n < beat_limit) ? n : beat_limit;
          gap = beat_gap;
          crg_dvld = 1'b0;
        end else if (left > 0 && busy) begin
          gap--;
          if (gap == 0) begin
            crg_dvld = 1'b1; left--; gap = beat_gap; last_beat_cyc = cyc;
          end else crg_dvld = 1'b0;
        end else begin
          crg_dvld = 1'b0; left = 0;
        end
        prev_run = crg_run;
      end
    end
  end

  initial begin : monitor
    logic prev_run, prev_er, prev_et;
    int run_len;
    exp_t e;
    prev_run = 1'b0; prev_er = 1'b0; prev_et = 1'b0; run_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_run = 1'b0; prev_er = 1'b0; prev_et = 1'b0; run_len = 0;
      end else begin
        if (crg_run) begin
          run_len++;
          if (!prev_run) run_pulses++;
        end else if (prev_run) begin
          chk("run_len", run_len, RUN_CYC);
          run_len = 0;
        end
        if (done) begin
          if (sb.size() == 0) chk("done_unexpected_sb_size", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("done_event_kind", K_DONE, e.kind);
            chk_cfg("done_cfg", e.job);
            chk("done_jobs_done", jobs_done, e.jd);
            chk("done_latency", cyc, last_beat_cyc + 1);
          end
        end
        if (err_range && !prev_er) begin
          if (sb.size() == 0) chk("range_unexpected_sb_size", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("range_event_kind", K_RANGE, e.kind);
            chk_cfg("range_cfg", e.job);
            chk("range_jobs_done", jobs_done, e.jd);
          end
        end
        // Error lands TIMEOUT edges after the edge that sampled the last beat.
        if (err_timeout && !prev_et) begin
          if (sb.size() == 0) chk("tmo_unexpected_sb_size", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("tmo_event_kind", K_TMO, e.kind);
            chk("tmo_cycle", cyc, last_beat_cyc + TIMEOUT + 1);
            chk("tmo_jobs_done", jobs_done, e.jd);
          end
        end
        prev_run = crg_run; prev_er = err_range; prev_et = err_timeout;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    job_t j, jb[5];
    int t, rp;
    repeat (3) @(negedge clk);
    chk("rst_rdy", job_rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_run", crg_run, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_jobs_done", jobs_done, 16'd0);
    chk("rst_errs", {err_range, err_timeout}, 2'b00);
    chk("rst_key", crg_key, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job, range 5..7, beats 7 cycles apart.
    beat_gap = 7;
    j = mk(128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 8'h20, 4'h3, 16'd5, 16'd7, 1'b1);
    expect_ev(K_DONE, j);
    push_job(j);
    t = cyc;
    chk("t1_busy_at_push", busy, 1'b0);
    @(negedge clk);
    chk("t1_run_at_t1", crg_run, 1'b0);
    chk("t1_busy_at_t1", busy, 1'b1);
    @(negedge clk);
    chk("t1_run_at_t2", crg_run, 1'b1);
    chk("t1_cyc_t2", cyc, t + 2);
    chk_cfg("t1_cfg_t2", j);
    wait_idle("t1", 200);
    chk("t1_jobs_done", jobs_done, 16'd1);
    chk("t1_busy_after", busy, 1'b0);

    // Five jobs back to back, queue fills behind the running job.
    beat_gap = 3;
    for (int i = 0; i < 5; i++) begin
      jb[i] = mk({96'h0, 32'hA500_0000 + 32'(i)}, 8'(i * 3 + 1), 4'(i + 2),
                 16'(100 + 16 * i), 16'(100 + 16 * i + 2 + (i % 3)), 1'(i % 2));
      expect_ev(K_DONE, jb[i]);
      push_job(jb[i]);
    end
    chk("t2_rdy_full", job_rdy, 1'b0);
    chk("t2_busy", busy, 1'b1);
    wait_idle("t2", 400);
    chk("t2_jobs_done", jobs_done, 16'd6);
    chk("t2_rdy_after", job_rdy, 1'b1);

    // Bad range followed by a good job.
    beat_gap = 3;
    rp = run_pulses;
    j = mk(128'hBAD, 8'h11, 4'h1, 16'd10, 16'd9, 1'b0);
    expect_ev(K_RANGE, j);
    push_job(j);
    j = mk(128'h600D, 8'h22, 4'h2, 16'd20, 16'd22, 1'b1);
    expect_ev(K_DONE, j);
    push_job(j);
    wait_idle("t3", 200);
    chk("t3_run_pulses", run_pulses, rp + 1);
    chk("t3_err_range", err_range, 1'b1);
    chk("t3_err_timeout", err_timeout, 1'b0);
    chk("t3_jobs_done", jobs_done, 16'd7);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_err_range_cleared", err_range, 1'b0);

    // Timeout: four beats expected, only two delivered.
    beat_gap = 7;
    beat_limit = 2;
    j = mk(128'h7140, 8'h33, 4'h4, 16'd0, 16'd3, 1'b0);
    expect_ev(K_TMO, j);
    push_job(j);
    wait_idle("t4", 1300);
    chk("t4_err_timeout", err_timeout, 1'b1);
    chk("t4_err_range", err_range, 1'b0);
    chk("t4_jobs_done", jobs_done, 16'd7);
    beat_limit = 1000;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_err_timeout_cleared", err_timeout, 1'b0);

    // Abort during WAIT with two jobs queued and a coincident push.
    beat_gap = 7;
    push_job(mk(128'hAB0, 8'h1, 4'h1, 16'd0, 16'd99, 1'b0));
    push_job(mk(128'hAB1, 8'h2, 4'h2, 16'd0, 16'd5, 1'b0));
    push_job(mk(128'hAB2, 8'h3, 4'h3, 16'd0, 16'd5, 1'b1));
    repeat (10) @(negedge clk);
    chk("t5_pre_busy", busy, 1'b1);
    chk("t5_pre_run", crg_run, 1'b0);
    job_key = 128'hAB3; job_cnt_start = 16'd1; job_cnt_end = 16'd2; job_vld = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; job_vld = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rdy", job_rdy, 1'b1);
    chk("t5_errs", {err_range, err_timeout}, 2'b00);
    chk("t5_done", done, 1'b0);
    chk("t5_jobs_done", jobs_done, 16'd7);
    repeat (5) @(negedge clk);
    chk("t5_flushed_busy", busy, 1'b0);
    chk("t5_flushed_jobs_done", jobs_done, 16'd7);

    // Asynchronous reset in the middle of RUN.
    push_job(mk(128'hE0E0, 8'h44, 4'h5, 16'd0, 16'd2, 1'b1));
    repeat (3) @(negedge clk);
    chk("t6_pre_run", crg_run, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_run", crg_run, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rdy", job_rdy, 1'b1);
    chk("t6_key", crg_key, 128'd0);
    chk("t6_cfg_rest", {crg_width, crg_mode, crg_cnt_start, crg_cnt_end, crg_party}, '0);
    chk("t6_jobs_done", jobs_done, 16'd0);
    chk("t6_errs", {err_range, err_timeout, done}, 3'b000);
    sb.delete();
    exp_jobs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    j = mk(128'hF00D, 8'h55, 4'h6, 16'd1, 16'd3, 1'b0);
    expect_ev(K_DONE, j);
    push_job(j);
    wait_idle("t6", 200);
    chk("t6_jobs_done_after", jobs_done, 16'd1);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
